pmem_loader: RTL and testbench

PMEM_LOADER -- requirements
Module: pmem_loader

---
 rtl/pmem_loader.sv | 124 ++++++++++++
 tb/tb_pmem_loader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pmem_loader.sv
// pmem_loader: loads a length-prefixed big-endian word stream from a byte receiver into program memory.
// Ports: clock/reset (sync, active-high); start begins a load; rx_data/rx_valid carry received bytes;
// pmem_we/pmem_addr/pmem_wdata write one word per completed 4-byte group; cpu_reset holds the core
// while loading; busy marks a load in progress; done pulses on completion; error flags overflow/timeout.
module pmem_loader #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        pmem_we,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, FINISH} state_t;
  state_t      state_q, state_d;
  logic [15:0] len_q, len_d, widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] acc_q, acc_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        we_q, we_d, crst_q, crst_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        timeout, loading;
  assign loading = state_q == LEN_HI || state_q == LEN_LO || state_q == DATA;
  // the counter would reach TIMEOUT on this edge with no byte to reset it
  assign timeout = loading && !rx_valid && gap_q == GW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crst_d  = crst_q;
    err_d   = err_q;
    gap_d   = (loading && !rx_valid) ? gap_q + GW'(1) : '0;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = LEN_HI;
          crst_d  = 1'b1;
          err_d   = 1'b0;
        end
        LEN_HI: if (rx_valid) begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: if (rx_valid) begin
          len_d   = {len_q[15:8], rx_data};
          widx_d  = '0;
          bidx_d  = '0;
          state_d = len_d == 16'd0 ? FINISH : DATA;
          crst_d  = len_d != 16'd0;
        end
        DATA: if (rx_valid) begin
          acc_d  = {acc_q[15:0], rx_data};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            // words beyond capacity are drained but only flagged
            we_d    = 32'(widx_q) < DEPTH_W;
            err_d   = err_q | !we_d;
            addr_d  = we_d ? 32'(widx_q) : addr_q;
            wdata_d = we_d ? {acc_q, rx_data} : wdata_q;
            widx_d  = widx_q + 16'd1;
            if (widx_q == len_q - 16'd1) begin
              state_d = FINISH;
              crst_d  = 1'b0;
            end
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      acc_q   <= '0;
      gap_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      crst_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      acc_q   <= acc_d;
      gap_q   <= gap_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      err_q   <= err_d;
    end
  end
  assign pmem_we    = we_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign cpu_reset  = crst_q;
  assign busy       = loading;
  assign done       = state_q == FINISH;
  assign error      = err_q;
endmodule

// File: tb/tb_pmem_loader.sv
// tb_pmem_loader: directed per-cycle vector table plus an overflow sequence for pmem_loader.
module tb_pmem_loader;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        pmem_we, cpu_reset, busy, done, error;
  logic [31:0] pmem_addr, pmem_wdata;
  pmem_loader #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .pmem_we(pmem_we), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic r, s, v;
    logic [7:0] d;
    logic we;
    logic [31:0] a, w;
    logic cr, b, dn, er;
  } vec_t;
  vec_t tab[$];
  int n_cmp = 0, n_bad = 0;
  logic log_en = 1'b0;
  logic [31:0] wa[$], wd[$];
  int dn_cnt = 0;
  always @(negedge clock) if (log_en) begin
    if (pmem_we) begin
      wa.push_back(pmem_addr);
      wd.push_back(pmem_wdata);
    end
    if (done) dn_cnt++;
  end
  function automatic void add(logic r, s, v, logic [7:0] d, logic we, logic [31:0] a, w,
                              logic cr, b, dn, er);
    vec_t t;
    t.r = r; t.s = s; t.v = v; t.d = d; t.we = we; t.a = a; t.w = w;
    t.cr = cr; t.b = b; t.dn = dn; t.er = er;
    tab.push_back(t);
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask
  task automatic send(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
  endtask
  initial begin
    logic [31:0] wv;
    // reset and IDLE behaviour
    add(1,0,0,8'h00, 0,0,0, 1,0,0,0);
    add(0,0,1,8'h55, 0,0,0, 1,0,0,0);
    add(0,0,0,8'h00, 0,0,0, 1,0,0,0);
    // N=2: DEADBEEF, 0000002A; byte coincident with the first write
    add(0,1,0,8'h00, 0,0,0, 1,1,0,0);
    add(0,0,1,8'h00, 0,0,0, 1,1,0,0);
    add(0,0,1,8'h02, 0,0,0, 1,1,0,0);
    add(0,0,1,8'hDE, 0,0,0, 1,1,0,0);
    add(0,0,1,8'hAD, 0,0,0, 1,1,0,0);
    add(0,0,1,8'hBE, 0,0,0, 1,1,0,0);
    add(0,0,1,8'hEF, 1,0,32'hDEADBEEF, 1,1,0,0);
    add(0,0,1,8'h00, 0,0,32'hDEADBEEF, 1,1,0,0);
    add(0,0,0,8'h00, 0,0,32'hDEADBEEF, 1,1,0,0);
    add(0,0,1,8'h00, 0,0,32'hDEADBEEF, 1,1,0,0);
    add(0,0,1,8'h00, 0,0,32'hDEADBEEF, 1,1,0,0);
    add(0,0,1,8'h2A, 1,1,32'h0000002A, 0,0,1,0);
    add(0,0,0,8'h00, 0,1,32'h0000002A, 0,0,0,0);
    add(0,0,0,8'h00, 0,1,32'h0000002A, 0,0,0,0);
    // N=3 back-to-back, with a start mid-load that must be ignored
    add(0,1,0,8'h00, 0,1,32'h0000002A, 1,1,0,0);
    add(0,0,1,8'h00, 0,1,32'h0000002A, 1,1,0,0);
    add(0,0,1,8'h03, 0,1,32'h0000002A, 1,1,0,0);
    add(0,0,1,8'h11, 0,1,32'h0000002A, 1,1,0,0);
    add(0,0,1,8'h22, 0,1,32'h0000002A, 1,1,0,0);
    add(0,0,1,8'h33, 0,1,32'h0000002A, 1,1,0,0);
    add(0,0,1,8'h44, 1,0,32'h11223344, 1,1,0,0);
    add(0,1,1,8'h55, 0,0,32'h11223344, 1,1,0,0);
    add(0,0,1,8'h66, 0,0,32'h11223344, 1,1,0,0);
    add(0,0,1,8'h77, 0,0,32'h11223344, 1,1,0,0);
    add(0,0,1,8'h88, 1,1,32'h55667788, 1,1,0,0);
    add(0,0,1,8'h99, 0,1,32'h55667788, 1,1,0,0);
    add(0,0,1,8'hAA, 0,1,32'h55667788, 1,1,0,0);
    add(0,0,1,8'hBB, 0,1,32'h55667788, 1,1,0,0);
    add(0,0,1,8'hCC, 1,2,32'h99AABBCC, 0,0,1,0);
    add(0,0,0,8'h00, 0,2,32'h99AABBCC, 0,0,0,0);
    // N=0: done the cycle after the second length byte
    add(0,1,0,8'h00, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h00, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h00, 0,2,32'h99AABBCC, 0,0,1,0);
    add(0,0,0,8'h00, 0,2,32'h99AABBCC, 0,0,0,0);
    // timeout after two data bytes: 15 idle cycles survive, the 16th aborts
    add(0,1,0,8'h00, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h00, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h01, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'hAA, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'hBB, 0,2,32'h99AABBCC, 1,1,0,0);
    for (int i = 0; i < 15; i++) add(0,0,0,8'h00, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,0,8'h00, 0,2,32'h99AABBCC, 1,0,0,1);
    add(0,0,0,8'h00, 0,2,32'h99AABBCC, 1,0,0,1);
    // reset after the 6th byte of an N=2 load, then a fresh load
    add(0,1,0,8'h00, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h00, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h02, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h12, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h34, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h56, 0,2,32'h99AABBCC, 1,1,0,0);
    add(0,0,1,8'h78, 1,0,32'h12345678, 1,1,0,0);
    add(1,0,1,8'h9A, 0,0,0, 1,0,0,0);
    add(0,0,1,8'hBC, 0,0,0, 1,0,0,0);
    add(0,0,0,8'h00, 0,0,0, 1,0,0,0);
    add(0,1,0,8'h00, 0,0,0, 1,1,0,0);
    add(0,0,1,8'h00, 0,0,0, 1,1,0,0);
    add(0,0,1,8'h01, 0,0,0, 1,1,0,0);
    add(0,0,1,8'hCA, 0,0,0, 1,1,0,0);
    add(0,0,1,8'hFE, 0,0,0, 1,1,0,0);
    add(0,0,1,8'hBA, 0,0,0, 1,1,0,0);
    add(0,0,1,8'hBE, 1,0,32'hCAFEBABE, 0,0,1,0);
    add(0,0,0,8'h00, 0,0,32'hCAFEBABE, 0,0,0,0);
    @(negedge clock);
    foreach (tab[i]) begin
      reset = tab[i].r; start = tab[i].s; rx_valid = tab[i].v; rx_data = tab[i].d;
      @(posedge clock);
      #1;
      n_cmp++;
      if ({pmem_we, pmem_addr, pmem_wdata, cpu_reset, busy, done, error} !==
          {tab[i].we, tab[i].a, tab[i].w, tab[i].cr, tab[i].b, tab[i].dn, tab[i].er}) begin
        n_bad++;
        $display("FAIL vec%0d: got we=%b addr=%h wdata=%h cpu_reset=%b busy=%b done=%b error=%b, want we=%b addr=%h wdata=%h cpu_reset=%b busy=%b done=%b error=%b",
                 i, pmem_we, pmem_addr, pmem_wdata, cpu_reset, busy, done, error,
                 tab[i].we, tab[i].a, tab[i].w, tab[i].cr, tab[i].b, tab[i].dn, tab[i].er);
      end
      @(negedge clock);
    end
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
    // overflow: DEPTH=4, N=5 -> four writes, fifth word drained, done and error
    log_en = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("ovf busy", 32'(busy), 1);
    send(8'h00);
    send(8'h05);
    for (int k = 0; k < 5; k++) begin
      wv = 32'hA0B0C000 + 32'(k);
      send(wv[31:24]);
      send(wv[23:16]);
      send(wv[15:8]);
      send(wv[7:0]);
    end
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);
    log_en = 1'b0;
    chk("ovf writes", 32'(wa.size()), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wa.size()) begin
        chk($sformatf("ovf addr%0d", k), wa[k], 32'(k));
        chk($sformatf("ovf data%0d", k), wd[k], 32'hA0B0C000 + 32'(k));
      end
    end
    chk("ovf done", 32'(dn_cnt), 1);
    chk("ovf error", 32'(error), 1);
    chk("ovf cpu_reset", 32'(cpu_reset), 0);
    chk("ovf busy end", 32'(busy), 0);
    // a new start clears the sticky error and re-holds the core
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("restart error", 32'(error), 0);
    chk("restart cpu_reset", 32'(cpu_reset), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
